// File: rtl/frame_write_arbiter.sv
// frame_write_arbiter: packs serial pixel bits from a UART receiver into RAM
// words and shares one single-port RAM between frame writes and display reads.
// Reads normally win; a held word is forced out once it has waited WR_MAX_WAIT.
module frame_write_arbiter #(
  parameter int LINE_PIXELS = 384,
  parameter int FRAME_LINES = 256,
  parameter int WORD_BITS   = 8,
  parameter int ADDR_W      = 14,
  parameter int WR_MAX_WAIT = 4
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  input  logic                 frame_restart,
  input  logic                 rd_req,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic                 rd_grant,
  output logic                 rd_valid,
  output logic [WORD_BITS-1:0] rd_data,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [WORD_BITS-1:0] mem_wdata,
  input  logic [WORD_BITS-1:0] mem_rdata,
  output logic                 frame_done,
  output logic                 overflow
);
  localparam int PIX_W  = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;
  localparam int LINE_W = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
  localparam int BIT_W  = $clog2(WORD_BITS + 1);
  localparam int WAIT_W = $clog2(WR_MAX_WAIT + 1);
  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(LINE_PIXELS - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(FRAME_LINES - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_BITS - 1);
  localparam logic [ADDR_W-1:0] WORD_LAST = ADDR_W'(LINE_PIXELS * FRAME_LINES / WORD_BITS - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(WR_MAX_WAIT);

  typedef enum logic {IDLE, PEND} state_t;

  state_t                state_q, state_d;
  logic                  bv_s1_q, bv_s1_d, bv_s2_q, bv_s2_d, bv_s3_q, bv_s3_d;
  logic                  bi_s1_q, bi_s1_d, bi_s2_q, bi_s2_d;
  logic [WORD_BITS-1:0]  shift_q, shift_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [PIX_W-1:0]      pix_cnt_q, pix_cnt_d;
  logic [LINE_W-1:0]     line_cnt_q, line_cnt_d;
  logic [ADDR_W-1:0]     word_addr_q, word_addr_d;
  logic [ADDR_W-1:0]     hold_addr_q, hold_addr_d;
  logic [WORD_BITS-1:0]  hold_data_q, hold_data_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  frame_done_q, frame_done_d;
  logic                  overflow_q, overflow_d;

  logic                  pix_evt, word_cmp, wr_issue, rd_gnt, drop;
  logic [WORD_BITS-1:0]  word_new;

  // Next-state logic: pixel capture, word assembly, counters, write FSM, arbitration
  always_comb begin
    pix_evt   = bv_s2_q & ~bv_s3_q & ~frame_restart;
    word_cmp  = pix_evt & (bit_cnt_q == BIT_LAST);
    word_new  = {shift_q[WORD_BITS-2:0], bi_s2_q};
    wr_issue  = RST_N & (state_q == PEND) & (~rd_req | (wait_q >= WAIT_MAX));
    rd_gnt    = RST_N & rd_req & ~wr_issue;
    drop      = word_cmp & (state_q == PEND) & ~wr_issue;

    bv_s1_d      = bit_valid;
    bv_s2_d      = bv_s1_q;
    bv_s3_d      = bv_s2_q;
    bi_s1_d      = bit_in;
    bi_s2_d      = bi_s1_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    pix_cnt_d    = pix_cnt_q;
    line_cnt_d   = line_cnt_q;
    word_addr_d  = word_addr_q;
    state_d      = state_q;
    hold_addr_d  = hold_addr_q;
    hold_data_d  = hold_data_q;
    wait_d       = wait_q;
    overflow_d   = overflow_q;
    rd_valid_d   = rd_gnt;
    frame_done_d = (wr_issue & (hold_addr_q == WORD_LAST)) | (drop & (word_addr_q == WORD_LAST));

    if (frame_restart) begin
      shift_d     = '0;
      bit_cnt_d   = '0;
      pix_cnt_d   = '0;
      line_cnt_d  = '0;
      word_addr_d = '0;
    end else if (pix_evt) begin
      if (word_cmp) begin
        shift_d     = '0;
        bit_cnt_d   = '0;
        word_addr_d = (word_addr_q == WORD_LAST) ? '0 : word_addr_q + ADDR_W'(1);
      end else begin
        shift_d   = word_new;
        bit_cnt_d = bit_cnt_q + BIT_W'(1);
      end
      if (pix_cnt_q == PIX_LAST) begin
        pix_cnt_d  = '0;
        line_cnt_d = (line_cnt_q == LINE_LAST) ? '0 : line_cnt_q + LINE_W'(1);
      end else begin
        pix_cnt_d = pix_cnt_q + PIX_W'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (word_cmp) begin
          state_d     = PEND;
          hold_addr_d = word_addr_q;
          hold_data_d = word_new;
          wait_d      = '0;
        end
      end
      PEND: begin
        if (wr_issue) begin
          wait_d = '0;
          if (word_cmp) begin
            hold_addr_d = word_addr_q;
            hold_data_d = word_new;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (wait_q < WAIT_MAX) wait_d = wait_q + WAIT_W'(1);
          if (word_cmp) overflow_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      bv_s1_q      <= 1'b0;
      bv_s2_q      <= 1'b0;
      bv_s3_q      <= 1'b0;
      bi_s1_q      <= 1'b0;
      bi_s2_q      <= 1'b0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      pix_cnt_q    <= '0;
      line_cnt_q   <= '0;
      word_addr_q  <= '0;
      hold_addr_q  <= '0;
      hold_data_q  <= '0;
      wait_q       <= '0;
      rd_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bv_s1_q      <= bv_s1_d;
      bv_s2_q      <= bv_s2_d;
      bv_s3_q      <= bv_s3_d;
      bi_s1_q      <= bi_s1_d;
      bi_s2_q      <= bi_s2_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      pix_cnt_q    <= pix_cnt_d;
      line_cnt_q   <= line_cnt_d;
      word_addr_q  <= word_addr_d;
      hold_addr_q  <= hold_addr_d;
      hold_data_q  <= hold_data_d;
      wait_q       <= wait_d;
      rd_valid_q   <= rd_valid_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

  // RAM port: write of the held word, else granted read, else idle
  always_comb begin
    rd_grant  = rd_gnt;
    mem_en    = rd_gnt | wr_issue;
    mem_we    = wr_issue;
    mem_addr  = wr_issue ? hold_addr_q : (rd_gnt ? rd_addr : '0);
    mem_wdata = wr_issue ? hold_data_q : '0;
    rd_valid  = rd_valid_q;
    rd_data   = rd_valid_q ? mem_rdata : '0;
    frame_done = frame_done_q;
    overflow   = overflow_q;
  end

endmodule

// File: tb/tb_frame_write_arbiter.sv
// Testbench for frame_write_arbiter: a small-frame instance for function and
// frame-wrap checks, and a long-wait instance that can be made to overflow.
module tb_frame_write_arbiter;
  localparam int LP = 24, FL = 4, WB = 8, AW = 14, MW = 4, MW_B = 30;
  localparam int NW = LP * FL / WB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0, bit_in = 1'b0, bit_valid = 1'b0, frame_restart = 1'b0, rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [WB-1:0] mem_rdata = '0;

  logic          a_rd_grant, a_rd_valid, a_mem_en, a_mem_we, a_frame_done, a_overflow;
  logic [WB-1:0] a_rd_data, a_mem_wdata;
  logic [AW-1:0] a_mem_addr;
  logic          b_rd_grant, b_rd_valid, b_mem_en, b_mem_we, b_frame_done, b_overflow;
  logic [WB-1:0] b_rd_data, b_mem_wdata;
  logic [AW-1:0] b_mem_addr;

  frame_write_arbiter #(.LINE_PIXELS(LP), .FRAME_LINES(FL), .WORD_BITS(WB), .ADDR_W(AW),
                        .WR_MAX_WAIT(MW)) dut (
    .CLK(clk), .RST_N(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .frame_restart(frame_restart), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_grant(a_rd_grant), .rd_valid(a_rd_valid), .rd_data(a_rd_data),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(mem_rdata), .frame_done(a_frame_done), .overflow(a_overflow));

  frame_write_arbiter #(.LINE_PIXELS(LP), .FRAME_LINES(FL), .WORD_BITS(WB), .ADDR_W(AW),
                        .WR_MAX_WAIT(MW_B)) dut_b (
    .CLK(clk), .RST_N(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .frame_restart(frame_restart), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_grant(b_rd_grant), .rd_valid(b_rd_valid), .rd_data(b_rd_data),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(mem_rdata), .frame_done(b_frame_done), .overflow(b_overflow));

  typedef struct {
    logic          rq;
    logic [AW-1:0] ra;
    logic          g;
    logic          en;
    logic          we;
    logic [AW-1:0] ma;
    logic [WB-1:0] wd;
  } vec_t;

  int   checks = 0, failures = 0, cyc_n = 0;
  logic rand_rd = 1'b0, exp_vld = 1'b0;
  int   wq_addr[$], wq_data[$], wq_cyc[$], bq_addr[$], bq_data[$], fd_cyc[$], tset[$], exp_w[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Negedge half of a cycle: protocol rules and capture of writes / frame_done
  task automatic half();
    @(negedge clk);
    cyc_n++;
    chk("rd_valid_follows_grant", 32'(a_rd_valid), 32'(exp_vld));
    if (a_rd_valid) chk("rd_data_passthru", 32'(a_rd_data), 32'(mem_rdata));
    chk("grant_write_exclusive", 32'(a_rd_grant & a_mem_we), 32'd0);
    if (a_rd_grant) chk("rd_addr_to_mem", 32'(a_mem_addr), 32'(rd_addr));
    if (rd_req && rst_n && !a_mem_we) chk("read_wins", 32'(a_rd_grant), 32'd1);
    if (a_mem_en && a_mem_we) begin
      wq_addr.push_back(int'(a_mem_addr));
      wq_data.push_back(int'(a_mem_wdata));
      wq_cyc.push_back(cyc_n);
    end
    if (b_mem_en && b_mem_we) begin
      bq_addr.push_back(int'(b_mem_addr));
      bq_data.push_back(int'(b_mem_wdata));
    end
    if (a_frame_done) fd_cyc.push_back(cyc_n);
    exp_vld = a_rd_grant & rst_n;
  endtask

  task automatic rise();
    @(posedge clk);
    #1;
    if (rand_rd) begin
      rd_req    = 1'($urandom_range(0, 1));
      rd_addr   = AW'($urandom);
      mem_rdata = WB'($urandom);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      half();
      rise();
    end
  endtask

  task automatic send_pixel(input logic b, input int hi, input int lo);
    bit_in    = b;
    bit_valid = 1'b1;
    cyc(hi);
    bit_valid = 1'b0;
    cyc(lo);
  endtask

  task automatic send_word(input logic [7:0] w, input int hi, input int lo);
    for (int k = 7; k >= 0; k--) send_pixel(w[k], hi, lo);
  endtask

  task automatic clear_q();
    wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
    bq_addr.delete(); bq_data.delete(); fd_cyc.delete();
  endtask

  task automatic do_reset();
    rand_rd = 1'b0; rst_n = 1'b0; rd_req = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    frame_restart = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(1);
    clear_q();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tv[10];
    logic [7:0] w;
    int nd;

    // Reset state
    cyc(3);
    chk("rst_rd_grant", 32'(a_rd_grant), 32'd0);
    chk("rst_rd_valid", 32'(a_rd_valid), 32'd0);
    chk("rst_rd_data", 32'(a_rd_data), 32'd0);
    chk("rst_mem_en", 32'(a_mem_en), 32'd0);
    chk("rst_mem_we", 32'(a_mem_we), 32'd0);
    chk("rst_mem_addr", 32'(a_mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(a_mem_wdata), 32'd0);
    chk("rst_frame_done", 32'(a_frame_done), 32'd0);
    chk("rst_overflow", 32'(a_overflow), 32'd0);
    do_reset();

    // One word 1,0,1,1,0,0,1,0 without reads
    send_word(8'hB2, 2, 2);
    cyc(6);
    chk("w1_count", 32'(wq_addr.size()), 32'd1);
    if (wq_addr.size() > 0) begin
      chk("w1_addr", 32'(wq_addr[0]), 32'd0);
      chk("w1_data", 32'(wq_data[0]), 32'hB2);
    end

    // Second word 0xC3 completes under a continuous read request
    tv[0] = '{1'b1, 14'h100, 1'b1, 1'b1, 1'b0, 14'h100, 8'h00};
    tv[1] = '{1'b1, 14'h101, 1'b1, 1'b1, 1'b0, 14'h101, 8'h00};
    tv[2] = '{1'b1, 14'h102, 1'b1, 1'b1, 1'b0, 14'h102, 8'h00};
    tv[3] = '{1'b1, 14'h103, 1'b1, 1'b1, 1'b0, 14'h103, 8'h00};
    tv[4] = '{1'b1, 14'h104, 1'b1, 1'b1, 1'b0, 14'h104, 8'h00};
    tv[5] = '{1'b1, 14'h105, 1'b1, 1'b1, 1'b0, 14'h105, 8'h00};
    tv[6] = '{1'b1, 14'h106, 1'b1, 1'b1, 1'b0, 14'h106, 8'h00};
    tv[7] = '{1'b1, 14'h107, 1'b0, 1'b1, 1'b1, 14'h001, 8'hC3};
    tv[8] = '{1'b1, 14'h108, 1'b1, 1'b1, 1'b0, 14'h108, 8'h00};
    tv[9] = '{1'b0, 14'h109, 1'b0, 1'b0, 1'b0, 14'h000, 8'h00};
    w = 8'hC3;
    for (int k = 7; k >= 1; k--) send_pixel(w[k], 2, 2);
    bit_in = w[0];
    bit_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rd_req  = tv[i].rq;
      rd_addr = tv[i].ra;
      half();
      chk($sformatf("tv%0d_grant", i), 32'(a_rd_grant), 32'(tv[i].g));
      chk($sformatf("tv%0d_en", i), 32'(a_mem_en), 32'(tv[i].en));
      chk($sformatf("tv%0d_we", i), 32'(a_mem_we), 32'(tv[i].we));
      chk($sformatf("tv%0d_addr", i), 32'(a_mem_addr), 32'(tv[i].ma));
      chk($sformatf("tv%0d_wdata", i), 32'(a_mem_wdata), 32'(tv[i].wd));
      rise();
    end
    bit_valid = 1'b0;
    cyc(3);

    // Read at 0x005 returns 0x5A one cycle later
    rd_req = 1'b1; rd_addr = 14'h005;
    half();
    chk("rd5_grant", 32'(a_rd_grant), 32'd1);
    chk("rd5_addr", 32'(a_mem_addr), 32'h005);
    rise();
    rd_req = 1'b0; mem_rdata = 8'h5A;
    half();
    chk("rd5_valid", 32'(a_rd_valid), 32'd1);
    chk("rd5_data", 32'(a_rd_data), 32'h5A);
    rise();
    half();
    chk("rd5_valid_drop", 32'(a_rd_valid), 32'd0);
    rise();

    // Overflow: second word completes while the first is still blocked
    do_reset();
    rd_req = 1'b1; rd_addr = 14'h03F;
    send_word(8'hA5, 1, 1);
    send_word(8'h3C, 1, 1);
    cyc(2);
    chk("ovf_b_set", 32'(b_overflow), 32'd1);
    chk("ovf_a_clear", 32'(a_overflow), 32'd0);
    rd_req = 1'b0;
    cyc(3);
    send_word(8'h81, 2, 2);
    cyc(6);
    chk("ovf_b_count", 32'(bq_addr.size()), 32'd2);
    if (bq_addr.size() == 2) begin
      chk("ovf_b_addr0", 32'(bq_addr[0]), 32'd0);
      chk("ovf_b_data0", 32'(bq_data[0]), 32'hA5);
      chk("ovf_b_addr1", 32'(bq_addr[1]), 32'd2);
      chk("ovf_b_data1", 32'(bq_data[1]), 32'h81);
    end
    chk("ovf_b_sticky", 32'(b_overflow), 32'd1);
    chk("ovf_a_count", 32'(wq_addr.size()), 32'd3);
    if (wq_addr.size() == 3) chk("ovf_a_addr2", 32'(wq_addr[2]), 32'd2);

    // Full frame plus one word: wrap and single frame_done pulse
    do_reset();
    exp_w.delete();
    for (int i = 0; i <= NW; i++) begin
      w = 8'($urandom);
      exp_w.push_back(int'(w));
      send_word(w, 1, 1);
    end
    cyc(6);
    chk("frame_count", 32'(wq_addr.size()), 32'(NW + 1));
    for (int i = 0; i < wq_addr.size() && i <= NW; i++) begin
      chk($sformatf("frame_addr%0d", i), 32'(wq_addr[i]), 32'(i % NW));
      chk($sformatf("frame_data%0d", i), 32'(wq_data[i]), 32'(exp_w[i]));
    end
    chk("frame_done_count", 32'(fd_cyc.size()), 32'd1);
    if (fd_cyc.size() == 1 && wq_cyc.size() >= NW)
      chk("frame_done_timing", 32'(fd_cyc[0]), 32'(wq_cyc[NW-1] + 1));

    // frame_restart after 5 pixels, with a coincident pixel edge discarded
    do_reset();
    for (int i = 0; i < 5; i++) send_pixel(1'(i & 1), 2, 2);
    bit_in = 1'b0; bit_valid = 1'b1;
    cyc(2);
    frame_restart = 1'b1;
    cyc(1);
    frame_restart = 1'b0; bit_valid = 1'b0;
    cyc(2);
    send_word(8'hFF, 2, 2);
    cyc(6);
    chk("rst_frame_count", 32'(wq_addr.size()), 32'd1);
    if (wq_addr.size() == 1) begin
      chk("rst_frame_addr", 32'(wq_addr[0]), 32'd0);
      chk("rst_frame_data", 32'(wq_data[0]), 32'hFF);
    end

    // Pending word survives frame_restart at its captured address
    do_reset();
    send_word(8'h96, 2, 2);
    w = 8'h4D;
    for (int k = 7; k >= 1; k--) send_pixel(w[k], 2, 2);
    rd_req = 1'b1; bit_in = w[0]; bit_valid = 1'b1;
    cyc(3);
    frame_restart = 1'b1;
    cyc(1);
    frame_restart = 1'b0; bit_valid = 1'b0; rd_req = 1'b0;
    cyc(4);
    send_word(8'h27, 2, 2);
    cyc(6);
    chk("pend_rst_count", 32'(wq_addr.size()), 32'd3);
    if (wq_addr.size() == 3) begin
      chk("pend_rst_addr1", 32'(wq_addr[1]), 32'd1);
      chk("pend_rst_data1", 32'(wq_data[1]), 32'h4D);
      chk("pend_rst_addr2", 32'(wq_addr[2]), 32'd0);
      chk("pend_rst_data2", 32'(wq_data[2]), 32'h27);
    end

    // Reset mid-operation discards pending and partial words
    do_reset();
    rd_req = 1'b1; rd_addr = 14'h020;
    for (int k = 0; k < 7; k++) send_pixel(1'b1, 2, 2);
    bit_in = 1'b1; bit_valid = 1'b1;
    cyc(3);
    rst_n = 1'b0; bit_valid = 1'b0;
    cyc(2);
    rst_n = 1'b1; rd_req = 1'b0;
    cyc(6);
    chk("midrst_no_write", 32'(wq_addr.size()), 32'd0);
    for (int k = 0; k < 3; k++) send_pixel(1'b1, 2, 2);
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    send_word(8'h0F, 2, 2);
    cyc(6);
    chk("midrst_count", 32'(wq_addr.size()), 32'd1);
    if (wq_addr.size() == 1) begin
      chk("midrst_addr", 32'(wq_addr[0]), 32'd0);
      chk("midrst_data", 32'(wq_data[0]), 32'h0F);
    end
    chk("midrst_overflow", 32'(a_overflow), 32'd0);

    // Random pixel timing and random reads against a word-level model
    do_reset();
    exp_w.delete(); tset.delete();
    rand_rd = 1'b1;
    nd = 40;
    for (int i = 0; i < nd; i++) begin
      w = 8'($urandom);
      exp_w.push_back(int'(w));
      for (int k = 7; k >= 0; k--) begin
        bit_in = w[k];
        bit_valid = 1'b1;
        if (k == 0) tset.push_back(cyc_n + 1);
        cyc($urandom_range(1, 3));
        bit_valid = 1'b0;
        cyc($urandom_range(1, 3));
      end
    end
    cyc(10);
    rand_rd = 1'b0; rd_req = 1'b0;
    cyc(4);
    chk("rand_count", 32'(wq_addr.size()), 32'(nd));
    for (int i = 0; i < wq_addr.size() && i < nd; i++) begin
      chk($sformatf("rand_addr%0d", i), 32'(wq_addr[i]), 32'(i % NW));
      chk($sformatf("rand_data%0d", i), 32'(wq_data[i]), 32'(exp_w[i]));
      chk($sformatf("rand_late%0d", i), 32'(wq_cyc[i] <= tset[i] + 3 + MW), 32'd1);
      chk($sformatf("rand_early%0d", i), 32'(wq_cyc[i] >= tset[i] + 3), 32'd1);
    end
    chk("rand_frame_done", 32'(fd_cyc.size()), 32'(nd / NW));
    chk("rand_overflow", 32'(a_overflow), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/frame_write_arbiter.md
FRAME_WRITE_ARBITER -- requirements
Module: frame_write_arbiter

Interface
REQ-001 Parameters (name, default, meaning): LINE_PIXELS, 384, pixels per line; FRAME_LINES, 256, lines per frame; WORD_BITS, 8, pixels packed per RAM word; ADDR_W, 14, RAM address width; WR_MAX_WAIT, 4, max cycles a pending write may be deferred.
REQ-002 Ports (name, direction, width, meaning): CLK, in, 1, sole clock.
REQ-003 RST_N, in, 1, reset; synchronous, active-low.
REQ-004 bit_in, in, 1, pixel bit from UART receiver; asynchronous to CLK.
REQ-005 bit_valid, in, 1, receiver strobe, level held high one or more CLK cycles per bit; asynchronous to CLK.
REQ-006 frame_restart, in, 1, single-cycle pulse that restarts frame capture.
REQ-007 rd_req, in, 1, display read request; held high until granted.
REQ-008 rd_addr, in, ADDR_W, display read address.
REQ-009 rd_grant, out, 1, read accepted this cycle.
REQ-010 rd_valid, out, 1, rd_data valid.
REQ-011 rd_data, out, WORD_BITS, read word.
REQ-012 mem_en, out, 1; mem_we, out, 1; mem_addr, out, ADDR_W; mem_wdata, out, WORD_BITS; single-port RAM controls.
REQ-013 mem_rdata, in, WORD_BITS, RAM read data, one-cycle latency.
REQ-014 frame_done, out, 1, one-cycle pulse at end of frame.
REQ-015 overflow, out, 1, sticky: a word was dropped.

Function
REQ-016 bit_valid and bit_in SHALL each pass through a 2-flop synchronizer; a new pixel is the rising edge of synchronized bit_valid, and pixel value is synchronized bit_in on that cycle.
REQ-017 Pixels SHALL shift in MSB-first; after WORD_BITS pixels the assembled word is complete and the shifter clears.
REQ-018 Write FSM states: IDLE (no word held), PEND (one word held, awaiting RAM); IDLE->PEND on word complete; PEND->IDLE on write issue.
REQ-019 Word complete while in PEND and no write issues that cycle: drop new word, set overflow, still advance word address.
REQ-020 Word complete in the same cycle a PEND write issues: new word SHALL be captured and FSM stays PEND.
REQ-021 Word address SHALL increment per completed word (written or dropped), wrapping 0 after LINE_PIXELS*FRAME_LINES/WORD_BITS-1 (12287).
REQ-022 Pixel counter 0..LINE_PIXELS-1 and line counter 0..FRAME_LINES-1 SHALL advance per pixel; line wrap at 383; frame wrap at line 255 pixel 383.
REQ-023 frame_done SHALL pulse the cycle after the last word of a frame is written or dropped.
REQ-024 Arbitration per cycle: read wins if rd_req high, unless PEND wait counter >= WR_MAX_WAIT, then write wins; write issues whenever PEND and no rd_req.
REQ-025 Wait counter counts PEND cycles without a write, clears on write issue; saturates at WR_MAX_WAIT.
REQ-026 Granted read: rd_grant=1, mem_en=1, mem_we=0, mem_addr=rd_addr; next cycle rd_valid=1, rd_data=mem_rdata; otherwise rd_valid=0.
REQ-027 Issued write: mem_en=1, mem_we=1, mem_addr and mem_wdata from held word; rd_grant=0 that cycle.
REQ-028 No operation: mem_en=0, mem_we=0.
REQ-029 frame_restart SHALL clear shifter, pixel, line and word counters; a word already in PEND is still written at its captured address.
REQ-030 Pixel edge coinciding with frame_restart SHALL be discarded.
REQ-031 overflow clears only on reset.

Reset
REQ-032 RST_N low at a CLK edge: all outputs 0, FSM IDLE, counters, shifter, synchronizers and wait counter 0; reset mid-operation discards partial and pending words without writing.

Verification
REQ-033 8 pixel edges with bits 1,0,1,1,0,0,1,0, no reads -> one write, mem_addr=0, mem_wdata=0xB2.
REQ-034 Word pending, rd_req held continuously -> 4 reads granted, 5th cycle write issues, rd_grant=0, following cycle read granted.
REQ-035 Read rd_addr=0x005 granted, mem_rdata=0x5A -> next cycle rd_valid=1, rd_data=0x5A.
REQ-036 Second word completes while first pending and write blocked -> overflow=1, next write at address 0 holds first word, later word lands at address 2.
REQ-037 Full frame of 98304 pixels, no reads -> 12288 writes, frame_done single pulse after write to 12287, next word at address 0.
REQ-038 frame_restart after 5 pixels, then 8 pixels 0xFF -> write address 0, data 0xFF.
